io_input_capture: RTL and testbench

//   Input side of the processor IO path. When the CPU executes an input instruction it raises

---
 rtl/io_pkg.sv | 21 ++
 rtl/io_debounce.sv | 43 ++++
 rtl/io_input_capture.sv | 104 ++++++++++
 tb/tb_io_input_capture.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared widths, FSM encoding and decimal accumulate helper for the IO input path
package io_pkg;

    localparam int DIGIT_W = 4;
    localparam int VALUE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2
    } io_state_t;

    // x*10 + d built from shifts so no multiplier is inferred
    function automatic logic [VALUE_W-1:0] times_ten_add(
        input logic [VALUE_W-1:0] x,
        input logic [DIGIT_W-1:0] d
    );
        return (x << 3) + (x << 1) + {{(VALUE_W-DIGIT_W){1'b0}}, d};
    endfunction

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - key synchronizer, stability counter and press (1->0) pulse
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Everything resets to "released" so no press fires after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync_2;
                press <= ~sync_2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_input_capture.sv
// rtl/io_input_capture.sv - collects a decimal number from switches/keys on CPU input request
module io_input_capture
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_DIGITS      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               input_flag,
    input  logic [DIGIT_W-1:0] SW,
    input  logic               key_digit_n,
    input  logic               key_enter_n,
    output logic [VALUE_W-1:0] entry_value,
    output logic [DIGIT_W-1:0] digit_count,
    output logic [VALUE_W-1:0] user_value,
    output logic               input_ready,
    output logic               busy
);

    localparam logic [DIGIT_W-1:0] MAX_CNT  = DIGIT_W'(MAX_DIGITS);
    localparam logic [DIGIT_W-1:0] MAX_CODE = DIGIT_W'(9);

    io_state_t          state_q, state_d;
    logic [VALUE_W-1:0] entry_d, user_d;
    logic [DIGIT_W-1:0] count_d;
    logic               ready_d;
    logic [DIGIT_W-1:0] sw_sync_1, sw_sync_2;
    logic               digit_press, enter_press;

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_digit_key (
        .clk   (clk),
        .reset (reset),
        .key_n (key_digit_n),
        .press (digit_press)
    );

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_key (
        .clk   (clk),
        .reset (reset),
        .key_n (key_enter_n),
        .press (enter_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            entry_value <= '0;
            digit_count <= '0;
            user_value  <= '0;
            input_ready <= 1'b0;
            sw_sync_1   <= '0;
            sw_sync_2   <= '0;
        end else begin
            state_q     <= state_d;
            entry_value <= entry_d;
            digit_count <= count_d;
            user_value  <= user_d;
            input_ready <= ready_d;
            sw_sync_1   <= SW;
            sw_sync_2   <= sw_sync_1;
        end
    end

    // Within ENTRY a same-cycle digit is folded in before enter looks at the count.
    always_comb begin
        state_d = state_q;
        entry_d = entry_value;
        count_d = digit_count;
        user_d  = user_value;
        ready_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (input_flag) begin
                    state_d = ST_ENTRY;
                    entry_d = '0;
                    count_d = '0;
                end
            end
            ST_ENTRY: begin
                if (!input_flag) begin
                    state_d = ST_IDLE;
                end else begin
                    if (digit_press && (sw_sync_2 <= MAX_CODE) && (digit_count < MAX_CNT)) begin
                        entry_d = times_ten_add(entry_value, sw_sync_2);
                        count_d = digit_count + DIGIT_W'(1);
                    end
                    if (enter_press && (count_d != '0)) begin
                        user_d  = entry_d;
                        ready_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!input_flag) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_ENTRY);

endmodule

// File: tb/tb_io_input_capture.sv
// tb/tb_io_input_capture.sv - directed and randomized checks against a behavioural model
module tb_io_input_capture;

    localparam int D    = 4;
    localparam int MAXD = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        input_flag = 1'b0;
    logic [3:0]  SW = 4'd0;
    logic        key_digit_n = 1'b1;
    logic        key_enter_n = 1'b1;
    logic [31:0] entry_value;
    logic [3:0]  digit_count;
    logic [31:0] user_value;
    logic        input_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int ready_seen = 0;

    io_input_capture #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(MAXD)) dut (
        .clk         (clk),
        .reset       (reset),
        .input_flag  (input_flag),
        .SW          (SW),
        .key_digit_n (key_digit_n),
        .key_enter_n (key_enter_n),
        .entry_value (entry_value),
        .digit_count (digit_count),
        .user_value  (user_value),
        .input_ready (input_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=idle, 1=entry, 2=done
    int          m_phase = 0;
    logic [31:0] m_entry = 0;
    logic [31:0] m_user = 0;
    int          m_count = 0;
    bit          m_ready = 0;
    bit          kd_hist [0:D+1];
    bit          ke_hist [0:D+1];
    logic [3:0]  sw_hist [0:2];
    bit          kd_level = 1, ke_level = 1;
    bit          kd_press = 0, ke_press = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_entry = 0; m_user = 0; m_count = 0; m_ready = 0;
            for (int j = 0; j <= D + 1; j++) begin kd_hist[j] = 1; ke_hist[j] = 1; end
            for (int j = 0; j < 3; j++) sw_hist[j] = 4'd0;
            kd_level = 1; ke_level = 1; kd_press = 0; ke_press = 0;
        end else begin
            bit kd_flip, ke_flip;
            for (int j = D + 1; j > 0; j--) begin kd_hist[j] = kd_hist[j-1]; ke_hist[j] = ke_hist[j-1]; end
            kd_hist[0] = key_digit_n;
            ke_hist[0] = key_enter_n;
            sw_hist[2] = sw_hist[1]; sw_hist[1] = sw_hist[0]; sw_hist[0] = SW;
            m_ready = 0;
            case (m_phase)
                0: if (input_flag) begin m_phase = 1; m_entry = 0; m_count = 0; end
                1: begin
                    if (!input_flag) m_phase = 0;
                    else begin
                        if (kd_press && sw_hist[2] <= 9 && m_count < MAXD) begin
                            m_entry = m_entry * 32'd10 + {28'd0, sw_hist[2]};
                            m_count++;
                        end
                        if (ke_press && m_count >= 1) begin
                            m_user = m_entry; m_ready = 1; m_phase = 2;
                        end
                    end
                end
                default: if (!input_flag) m_phase = 0;
            endcase
            // a key level flips once the last D synchronized samples all disagree with it
            kd_flip = 1; ke_flip = 1;
            for (int j = 2; j <= D + 1; j++) begin
                if (kd_hist[j] == kd_level) kd_flip = 0;
                if (ke_hist[j] == ke_level) ke_flip = 0;
            end
            kd_press = kd_flip && kd_level;
            ke_press = ke_flip && ke_level;
            if (kd_flip) kd_level = ~kd_level;
            if (ke_flip) ke_level = ~ke_level;
        end
    end

    always @(negedge clk) begin
        check("entry_value", entry_value, m_entry);
        check("digit_count", 32'(digit_count), 32'(m_count));
        check("user_value", user_value, m_user);
        check("input_ready", 32'(input_ready), 32'(m_ready));
        check("busy", 32'(busy), 32'(m_phase == 1));
        if (input_ready === 1'b1) ready_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press_keys(input logic [3:0] sw, input bit dig, input bit ent);
        SW = sw;
        tick(3);
        if (dig) key_digit_n = 1'b0;
        if (ent) key_enter_n = 1'b0;
        tick(10);
        key_digit_n = 1'b1;
        key_enter_n = 1'b1;
        tick(10);
    endtask

    int r0;

    initial begin
        tick(3);
        check("reset entry", entry_value, 32'd0);
        check("reset count", 32'(digit_count), 32'd0);
        check("reset user", user_value, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(2);

        // 1: 3, 7, enter
        input_flag = 1'b1; tick(2);
        press_keys(4'd3, 1, 0);
        check("t1 entry 3", entry_value, 32'd3);
        press_keys(4'd7, 1, 0);
        check("t1 entry 37", entry_value, 32'd37);
        r0 = ready_seen;
        press_keys(4'd0, 0, 1);
        check("t1 user", user_value, 32'd37);
        check("t1 model user", m_user, 32'd37);
        check("t1 ready pulses", 32'(ready_seen - r0), 32'd1);
        check("t1 busy", 32'(busy), 32'd0);
        input_flag = 1'b0; tick(3);

        // 2: bouncing key yields one digit
        input_flag = 1'b1; SW = 4'd5; tick(3);
        for (int i = 0; i < 10; i++) begin key_digit_n = ~key_digit_n; tick(2); end
        key_digit_n = 1'b0; tick(12);
        key_digit_n = 1'b1; tick(10);
        check("t2 entry", entry_value, 32'd5);
        check("t2 count", 32'(digit_count), 32'd1);
        press_keys(4'd0, 0, 1);
        input_flag = 1'b0; tick(3);

        // 3: invalid digit, then enter with no digits
        input_flag = 1'b1; tick(2);
        r0 = ready_seen;
        press_keys(4'd12, 1, 0);
        check("t3 count", 32'(digit_count), 32'd0);
        press_keys(4'd0, 0, 1);
        check("t3 no ready", 32'(ready_seen - r0), 32'd0);
        check("t3 busy", 32'(busy), 32'd1);
        input_flag = 1'b0; tick(3);

        // 4: nine 9s saturate at eight digits
        input_flag = 1'b1; tick(2);
        for (int i = 0; i < 9; i++) press_keys(4'd9, 1, 0);
        check("t4 entry", entry_value, 32'd99_999_999);
        check("t4 count", 32'(digit_count), 32'd8);
        press_keys(4'd0, 0, 1);
        check("t4 user", user_value, 32'd99_999_999);
        input_flag = 1'b0; tick(3);

        // 5: abort mid-entry, then reset mid-debounce
        input_flag = 1'b1; tick(2);
        r0 = ready_seen;
        press_keys(4'd2, 1, 0);
        input_flag = 1'b0; tick(3);
        check("t5 busy", 32'(busy), 32'd0);
        check("t5 user kept", user_value, 32'd99_999_999);
        check("t5 entry held", entry_value, 32'd2);
        check("t5 no ready", 32'(ready_seen - r0), 32'd0);
        input_flag = 1'b1; tick(2);
        key_digit_n = 1'b0; tick(3);
        reset = 1'b1; tick(1);
        check("t5 rst user", user_value, 32'd0);
        check("t5 rst busy", 32'(busy), 32'd0);
        key_digit_n = 1'b1; tick(1);
        reset = 1'b0; tick(15);
        check("t5 no spurious", 32'(digit_count), 32'd0);
        check("t5 entry after rst", entry_value, 32'd0);

        // 6: digit and enter together
        r0 = ready_seen;
        press_keys(4'd4, 1, 0);
        check("t6 entry", entry_value, 32'd4);
        press_keys(4'd5, 1, 1);
        check("t6 user", user_value, 32'd45);
        check("t6 ready pulses", 32'(ready_seen - r0), 32'd1);
        input_flag = 1'b0; tick(3);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) input_flag = ~input_flag;
            SW = 4'($urandom_range(0, 11));
            key_digit_n = 1'($urandom_range(0, 1));
            key_enter_n = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            tick(int'($urandom_range(1, 9)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
